// File: rtl/t03_timer_pkg.sv
// Shared defaults and flag indexing for the team 03 system timer.
package t03_timer_pkg;

  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned PRE_W_DEF   = 16;
  localparam int unsigned NUM_CMP_DEF = 2;
  localparam int unsigned PRE_RST_DEF = 10000;

  // Overflow flag sits directly above the compare-channel flags.
  localparam int unsigned OVF_DEF = NUM_CMP_DEF;

  function automatic int unsigned ovf_idx(input int unsigned num_cmp);
    return num_cmp;
  endfunction

endpackage

// File: rtl/t03_timer_prescaler.sv
// Runtime-programmable prescaler: divisor register, pre_cnt and tick strobe.
module t03_timer_prescaler
  import t03_timer_pkg::*;
#(
  parameter int unsigned PRE_W   = PRE_W_DEF,
  parameter int unsigned PRE_RST = PRE_RST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             pre_wr_i,
  input  logic [PRE_W-1:0] pre_div_i,
  output logic             tick_c_o
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRE_W-1:0] divisor_q, divisor_d;

  // >= rather than == so a divisor lowered below pre_cnt ticks immediately.
  always_comb begin
    divisor_d = divisor_q;
    pre_cnt_d = pre_cnt_q;
    tick_c_o  = 1'b0;
    if (pre_wr_i) begin
      divisor_d = pre_div_i;
    end
    if (clr_i) begin
      pre_cnt_d = '0;
    end else if (en_i) begin
      if (pre_cnt_q >= divisor_q) begin
        pre_cnt_d = '0;
        tick_c_o  = 1'b1;
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt_q <= '0;
      divisor_q <= PRE_W'(PRE_RST);
    end else begin
      pre_cnt_q <= pre_cnt_d;
      divisor_q <= divisor_d;
    end
  end

endmodule

// File: rtl/t03_hw_timer.sv
// System timer: tick counter, sticky compare/overflow flags, snapshot and irq.
module t03_hw_timer
  import t03_timer_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned PRE_W   = PRE_W_DEF,
  parameter int unsigned NUM_CMP = NUM_CMP_DEF,
  parameter int unsigned PRE_RST = PRE_RST_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     pre_wr,
  input  logic [PRE_W-1:0]         pre_div_in,
  input  logic [NUM_CMP*CNT_W-1:0] cmp_val,
  input  logic [NUM_CMP:0]         flag_clr,
  input  logic                     snap,
  output logic                     tick,
  output logic [CNT_W-1:0]         count,
  output logic [CNT_W-1:0]         snap_q,
  output logic [NUM_CMP:0]         flags,
  output logic                     irq
);

  localparam int unsigned OVF = ovf_idx(NUM_CMP);

  logic               tick_c;
  logic [CNT_W-1:0]   count_q, count_d, count_inc_c;
  logic [CNT_W-1:0]   snapshot_q, snapshot_d;
  logic [NUM_CMP:0]   flags_q, flags_d, set_c;
  logic [NUM_CMP-1:0] match_c;
  logic               ovf_c;
  logic               tick_q, irq_q, irq_d;

  t03_timer_prescaler #(
    .PRE_W   (PRE_W),
    .PRE_RST (PRE_RST)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .clr_i     (clr),
    .pre_wr_i  (pre_wr),
    .pre_div_i (pre_div_in),
    .tick_c_o  (tick_c)
  );

  assign count_inc_c = count_q + CNT_W'(1);
  assign ovf_c       = tick_c && (count_q == '1);

  // Match only on the transition into cmp_val, never on a static equality.
  for (genvar g = 0; g < int'(NUM_CMP); g++) begin : g_cmp
    assign match_c[g] = tick_c && (count_inc_c == cmp_val[g*CNT_W +: CNT_W]);
  end

  always_comb begin
    count_d    = count_q;
    snapshot_d = snapshot_q;
    set_c      = '0;
    if (clr) begin
      count_d = '0;
    end else if (tick_c) begin
      count_d = count_inc_c;
    end
    if (snap) begin
      snapshot_d = count_q;
    end
    set_c[NUM_CMP-1:0] = match_c;
    set_c[OVF]         = ovf_c;
    flags_d            = (flags_q & ~flag_clr) | set_c;
    irq_d              = |flags_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      snapshot_q <= '0;
      flags_q    <= '0;
      tick_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      snapshot_q <= snapshot_d;
      flags_q    <= flags_d;
      tick_q     <= tick_c;
      irq_q      <= irq_d;
    end
  end

  assign tick   = tick_q;
  assign count  = count_q;
  assign snap_q = snapshot_q;
  assign flags  = flags_q;
  assign irq    = irq_q;

endmodule
